// File: rtl/writeback_stage.sv
// Writeback stage: selects and extracts the result, registers it for the
// register file, and counts retired instructions.
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             MemValid,
  input  logic             MemRegWrite,
  input  logic [4:0]       MemWriteAddr,
  input  logic [1:0]       MemToReg,
  input  logic [31:0]      MemAluResult,
  input  logic [31:0]      MemLoadData,
  input  logic [31:0]      MemLinkAddr,
  input  logic [1:0]       MemLoadSize,
  input  logic             MemLoadSigned,
  output logic             RegWrite,
  output logic [4:0]       WriteAddr,
  output logic [31:0]      WriteData,
  output logic             WbValid,
  output logic [CNT_W-1:0] RetireCount
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] wb_data;
  logic        wb_we;

  // Extraction sits ahead of the register so WriteData leaves a flop.
  always_comb begin
    ld_byte = MemLoadData[{MemAluResult[1:0], 3'b000} +: 8];
    ld_half = MemAluResult[1] ? MemLoadData[31:16] : MemLoadData[15:0];
    ld_val  = MemLoadData;
    case (MemLoadSize)
      2'b01:   ld_val = {{16{MemLoadSigned & ld_half[15]}}, ld_half};
      2'b10:   ld_val = {{24{MemLoadSigned & ld_byte[7]}}, ld_byte};
      default: ld_val = MemLoadData;
    endcase
    case (MemToReg)
      2'b01:   wb_data = ld_val;
      2'b10:   wb_data = MemLinkAddr;
      default: wb_data = MemAluResult;
    endcase
    wb_we = MemValid & MemRegWrite & (MemWriteAddr != 5'd0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      RegWrite    <= 1'b0;
      WbValid     <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      RetireCount <= '0;
    end else if (Flush) begin
      RegWrite <= 1'b0;
      WbValid  <= 1'b0;
    end else if (!Stall) begin
      RegWrite  <= wb_we;
      WbValid   <= MemValid;
      WriteAddr <= MemWriteAddr;
      WriteData <= wb_data;
      if (MemValid)
        RetireCount <= RetireCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage with a 4-bit retire counter.
module tb_writeback_stage;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Flush;
  logic        MemValid, MemRegWrite, MemLoadSigned;
  logic [4:0]  MemWriteAddr;
  logic [1:0]  MemToReg, MemLoadSize;
  logic [31:0] MemAluResult, MemLoadData, MemLinkAddr;
  logic        RegWrite, WbValid;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [3:0]  RetireCount;

  writeback_stage #(.CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite),
    .MemWriteAddr(MemWriteAddr), .MemToReg(MemToReg),
    .MemAluResult(MemAluResult), .MemLoadData(MemLoadData),
    .MemLinkAddr(MemLinkAddr), .MemLoadSize(MemLoadSize),
    .MemLoadSigned(MemLoadSigned), .RegWrite(RegWrite),
    .WriteAddr(WriteAddr), .WriteData(WriteData),
    .WbValid(WbValid), .RetireCount(RetireCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t last;
  logic [3:0] cnt_m;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] model_data(
    input logic [1:0] mtr, input logic [31:0] alu, ld, lnk,
    input logic [1:0] sz, input logic sg);
    logic [31:0] b, h, r;
    b = (ld >> (alu[1:0] * 8)) & 32'hFF;
    h = (ld >> (alu[1] * 16)) & 32'hFFFF;
    if (sg && b[7]) b = b | 32'hFFFFFF00;
    if (sg && h[15]) h = h | 32'hFFFF0000;
    r = (sz == 2'b10) ? b : (sz == 2'b01) ? h : ld;
    if (mtr == 2'b01) return r;
    if (mtr == 2'b10) return lnk;
    return alu;
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle;
    Reset = 0; Stall = 0; Flush = 0;
    MemValid = 0; MemRegWrite = 0; MemWriteAddr = 0; MemToReg = 0;
    MemAluResult = 0; MemLoadData = 0; MemLinkAddr = 0;
    MemLoadSize = 0; MemLoadSigned = 0;
  endtask

  // Drive one capture cycle and push its expected outcome.
  task automatic apply(input logic v, rw, input logic [4:0] a,
                       input logic [1:0] mtr, input logic [31:0] alu,
                       input logic [31:0] ld, lnk,
                       input logic [1:0] sz, input logic sg);
    exp_t x;
    Stall = 0; Flush = 0; Reset = 0;
    MemValid = v; MemRegWrite = rw; MemWriteAddr = a; MemToReg = mtr;
    MemAluResult = alu; MemLoadData = ld; MemLinkAddr = lnk;
    MemLoadSize = sz; MemLoadSigned = sg;
    if (v) cnt_m = cnt_m + 4'd1;
    x.v = v;
    x.rw = v & rw & (a != 0);
    x.a = a;
    x.d = model_data(mtr, alu, ld, lnk, sz, sg);
    x.c = cnt_m;
    q.push_back(x);
    last = x;
  endtask

  task automatic do_reset;
    idle();
    Reset = 1;
    tick();
    Reset = 0;
    cnt_m = 0;
    q.delete();
  endtask

  task automatic test_reset;
    idle();
    Reset = 1; Stall = 1; Flush = 1;
    tick();
    idle();
    cnt_m = 0;
    vectors++;
    if ({WbValid, RegWrite, WriteAddr, WriteData, RetireCount} !== '0) begin
      miscompares++;
      $display("FAIL reset: got v=%b rw=%b a=%0d d=%h c=%0d want all 0",
               WbValid, RegWrite, WriteAddr, WriteData, RetireCount);
    end
  endtask

  task automatic test_alu;
    do_reset();
    apply(1, 1, 5, 2'b00, 32'h12345678, 32'h0, 32'h0, 2'b00, 0);
    tick();
    e = q.pop_front();
    vectors++;
    if ({WbValid, RegWrite, WriteAddr, WriteData, RetireCount} !==
        {1'b1, 1'b1, 5'd5, 32'h12345678, 4'd1} ||
        WriteData !== e.d) begin
      miscompares++;
      $display("FAIL alu: got rw=%b a=%0d d=%h c=%0d want rw=1 a=5 d=12345678 c=1",
               RegWrite, WriteAddr, WriteData, RetireCount);
    end
  endtask

  task automatic test_loads;
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080,
                              32'hFFFF80FF, 32'h80FF7F01};
    logic [1:0]  sz   [4] = '{2'b10, 2'b10, 2'b01, 2'b11};
    logic        sg   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] off  [4] = '{32'd3, 32'd3, 32'd3, 32'd2};
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 5'd7, 2'b01, off[i], 32'h80FF7F01, 32'h0, sz[i], sg[i]);
      tick();
      e = q.pop_front();
      vectors++;
      if (WriteData !== want[i] || WriteData !== e.d ||
          RetireCount !== e.c || RegWrite !== 1'b1) begin
        miscompares++;
        $display("FAIL load%0d: got d=%h c=%0d rw=%b want d=%h c=%0d rw=1",
                 i, WriteData, RetireCount, RegWrite, want[i], e.c);
      end
    end
  endtask

  task automatic test_link;
    logic [3:0] c0;
    apply(1, 1, 31, 2'b10, 32'hDEAD0000, 32'h0, 32'h00400010, 2'b00, 0);
    tick();
    e = q.pop_front();
    vectors++;
    if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd31, 32'h00400010} ||
        RetireCount !== e.c) begin
      miscompares++;
      $display("FAIL link: got rw=%b a=%0d d=%h c=%0d want rw=1 a=31 d=00400010 c=%0d",
               RegWrite, WriteAddr, WriteData, RetireCount, e.c);
    end
    c0 = RetireCount;
    apply(1, 1, 0, 2'b10, 32'hDEAD0000, 32'h0, 32'h00400010, 2'b00, 0);
    tick();
    e = q.pop_front();
    vectors++;
    if (RegWrite !== 1'b0 || WbValid !== 1'b1 ||
        RetireCount !== c0 + 4'd1 || RetireCount !== e.c) begin
      miscompares++;
      $display("FAIL link_x0: got rw=%b v=%b c=%0d want rw=0 v=1 c=%0d",
               RegWrite, WbValid, RetireCount, e.c);
    end
  endtask

  task automatic test_stall_flush;
    apply(1, 1, 9, 2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 2'b00, 0);
    tick();
    e = q.pop_front();
    Stall = 1;
    MemValid = 1; MemWriteAddr = 3; MemAluResult = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({WbValid, RegWrite, WriteAddr, WriteData, RetireCount} !==
          {last.v, last.rw, last.a, last.d, last.c}) begin
        miscompares++;
        $display("FAIL stall%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                 i, WriteAddr, WriteData, RetireCount, last.a, last.d, last.c);
      end
    end
    Flush = 1;
    tick();
    Flush = 0; Stall = 0; MemValid = 0;
    vectors++;
    if (WbValid !== 1'b0 || RegWrite !== 1'b0 || RetireCount !== cnt_m) begin
      miscompares++;
      $display("FAIL flush: got v=%b rw=%b c=%0d want v=0 rw=0 c=%0d",
               WbValid, RegWrite, RetireCount, cnt_m);
    end
    apply(0, 1, 4, 2'b00, 32'h5, 32'h0, 32'h0, 2'b00, 0);
    tick();
    e = q.pop_front();
    vectors++;
    if (WbValid !== 1'b0 || RegWrite !== 1'b0 || RetireCount !== e.c) begin
      miscompares++;
      $display("FAIL bubble: got v=%b rw=%b c=%0d want v=0 rw=0 c=%0d",
               WbValid, RegWrite, RetireCount, e.c);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apply(1, i[0], 5'(i + 1), 2'b00, 32'(i), 32'h0, 32'h0, 2'b00, 0);
      tick();
      e = q.pop_front();
    end
    vectors++;
    if (RetireCount !== 4'd15) begin
      miscompares++;
      $display("FAIL preload: got c=%0d want c=15", RetireCount);
    end
    apply(1, 1, 2, 2'b00, 32'h77, 32'h0, 32'h0, 2'b00, 0);
    tick();
    e = q.pop_front();
    vectors++;
    if (RetireCount !== 4'd0 || RetireCount !== e.c) begin
      miscompares++;
      $display("FAIL wrap: got c=%0d want c=0", RetireCount);
    end
  endtask

  task automatic test_reset_mid;
    apply(1, 1, 12, 2'b00, 32'hABCD1234, 32'h0, 32'h0, 2'b00, 0);
    tick();
    e = q.pop_front();
    Stall = 1;
    tick();
    Reset = 1;
    tick();
    Reset = 0; Stall = 0; MemValid = 0;
    cnt_m = 0;
    vectors++;
    if ({WbValid, RegWrite, WriteAddr, WriteData, RetireCount} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b rw=%b a=%0d d=%h c=%0d want all 0",
               WbValid, RegWrite, WriteAddr, WriteData, RetireCount);
    end
    tick();
    vectors++;
    if (RegWrite !== 1'b0 || WbValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after: got rw=%b v=%b want rw=0 v=0",
               RegWrite, WbValid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom),
            5'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
            2'($urandom), 1'($urandom));
      tick();
      e = q.pop_front();
      vectors++;
      if (WbValid !== e.v || RegWrite !== e.rw || RetireCount !== e.c ||
          (e.v && (WriteAddr !== e.a || WriteData !== e.d))) begin
        miscompares++;
        $display("FAIL b2b%0d: got v=%b rw=%b a=%0d d=%h c=%0d want v=%b rw=%b a=%0d d=%h c=%0d",
                 i, WbValid, RegWrite, WriteAddr, WriteData, RetireCount,
                 e.v, e.rw, e.a, e.d, e.c);
      end
    end
  endtask

  initial begin
    cnt_m = 0;
    idle();
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_stall_flush();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameters SHALL be: CNT_W, default 32, width of the retire counter.
REQ-002 Ports SHALL be, clock and reset first:
- Clock  in  1  the single clock; all state updates on its rising edge.
- Reset  in  1  synchronous reset, active-high.
- Stall  in  1  hold all stage state.
- Flush  in  1  replace the captured instruction with a bubble.
- MemValid  in  1  MEM stage presents a valid instruction.
- MemRegWrite  in  1  instruction writes a register.
- MemWriteAddr  in  5  destination register.
- MemToReg  in  2  result source: 00 ALU, 01 load, 10 link, 11 ALU.
- MemAluResult  in  32  ALU result; bits [1:0] are also the load byte offset.
- MemLoadData  in  32  raw aligned memory word.
- MemLinkAddr  in  32  return address for link instructions.
- MemLoadSize  in  2  00 word, 01 half, 10 byte, 11 word.
- MemLoadSigned  in  1  sign-extend (1) or zero-extend (0) sub-word loads.
- RegWrite  out  1  register file write enable.
- WriteAddr  out  5  register file write address.
- WriteData  out  32  register file write data.
- WbValid  out  1  WB stage holds a valid instruction.
- RetireCount  out  CNT_W  count of retired instructions.

Function
REQ-003 On a capture cycle the block SHALL register all Mem* inputs; outputs SHALL reflect them exactly 1 cycle later.
REQ-004 Update priority each rising edge SHALL be Reset > Flush > Stall > capture.
REQ-005 On Flush, WbValid SHALL become 0 and RegWrite 0; WriteAddr/WriteData don't-care, Flush overrides a simultaneous Stall.
REQ-006 On Stall without Flush, all registered state including RetireCount SHALL hold.
REQ-007 RegWrite SHALL equal captured MemValid AND MemRegWrite AND (MemWriteAddr != 0); a write to $0 is suppressed but still retires.
REQ-008 WriteData SHALL be the ALU result for MemToReg 00/11, MemLinkAddr for 10, and the extracted load value for 01.
REQ-009 Load extraction SHALL be little-endian: byte = MemLoadData[8k+7:8k] with k = MemAluResult[1:0]; half = MemLoadData[16h+15:16h] with h = MemAluResult[1]; word = MemLoadData unmodified.
REQ-010 Misaligned halves SHALL ignore MemAluResult[0]; word loads SHALL ignore MemAluResult[1:0].
REQ-011 Sub-word results SHALL be sign-extended from bit 7/15 when MemLoadSigned=1, zero-extended otherwise.
REQ-012 Load extraction SHALL be computed before the pipeline register so WriteData is a registered output.
REQ-013 RetireCount SHALL increment by 1 on every capture cycle with MemValid=1, independent of MemRegWrite, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-014 Flush SHALL NOT alter RetireCount, and a flushed instruction SHALL NOT be counted.
REQ-015 Capture with MemValid=0 SHALL produce WbValid=0 and RegWrite=0.

Reset
REQ-016 With Reset high at a rising edge, RegWrite, WbValid, WriteAddr, WriteData and RetireCount SHALL all become 0, overriding Stall and Flush.
REQ-017 Reset asserted mid-stream SHALL discard the held instruction, with no register write in the following cycle.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ALU op addr 5, result 0x12345678, valid -> next cycle RegWrite=1, WriteAddr=5, WriteData=0x12345678, RetireCount=1.
- Signed byte load, MemLoadData=0x80FF7F01, offset 3 -> WriteData=0xFFFFFF80; unsigned -> 0x00000080; signed half, offset 2 -> 0xFFFF80FF.
- Link op, MemToReg=10, addr 31, MemLinkAddr=0x00400010 -> WriteData=0x00400010; same op with addr 0 -> RegWrite=0, RetireCount still increments.
- Stall for 3 cycles after capture -> outputs and RetireCount constant; Stall+Flush together -> WbValid=0, RetireCount unchanged.
- RetireCount preloaded via 2^CNT_W-1 valid captures (CNT_W=4: 15) -> next valid capture gives 0.
- Reset asserted during Stall with a valid instruction held -> next cycle all outputs 0.
